// File: rtl/scan_pkg.sv
// Shared types and helpers for the scan_tester controller: FSM state encoding
// and the popcount used to score a scan response.
package scan_pkg;

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_LOAD    = 3'd1;
    localparam logic [2:0] ST_CAPTURE = 3'd2;
    localparam logic [2:0] ST_UNLOAD  = 3'd3;
    localparam logic [2:0] ST_CHECK   = 3'd4;

    typedef enum logic [2:0] {
        IDLE    = ST_IDLE,
        LOAD    = ST_LOAD,
        CAPTURE = ST_CAPTURE,
        UNLOAD  = ST_UNLOAD,
        CHECK   = ST_CHECK
    } state_t;

    // Widest chain the popcount helper can score; callers zero-extend into it.
    localparam int POP_W = 64;

    function automatic int popcount(input logic [POP_W-1:0] v);
        int n;
        n = 0;
        for (int i = 0; i < POP_W; i++) begin
            n = n + int'(v[i]);
        end
        return n;
    endfunction

endpackage

// File: rtl/scan_tester_if.sv
// Sequencer-side handshake bundle for scan_tester.
// The mask field exists only when SCAN_TESTER_MASK_EN is defined.
interface scan_tester_if #(
    parameter int CHAIN_LEN = 4
) ();
    localparam int CNT_W = $clog2(CHAIN_LEN + 1);

    logic                 start;
    logic [CHAIN_LEN-1:0] pattern;
    logic [CHAIN_LEN-1:0] expected;
`ifdef SCAN_TESTER_MASK_EN
    logic [CHAIN_LEN-1:0] mask;
`endif
    logic                 busy;
    logic                 done;
    logic                 pass;
    logic [CNT_W-1:0]     fail_count;
    logic [CHAIN_LEN-1:0] response;

    modport master (
        output start, pattern, expected,
`ifdef SCAN_TESTER_MASK_EN
        output mask,
`endif
        input  busy, done, pass, fail_count, response
    );

    modport slave (
        input  start, pattern, expected,
`ifdef SCAN_TESTER_MASK_EN
        input  mask,
`endif
        output busy, done, pass, fail_count, response
    );

endinterface

// File: rtl/scan_shift_reg.sv
// Shift-left register with serial input at the LSB and parallel load/output.
module scan_shift_reg #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             shift,
    input  logic             ser_in,
    output logic [WIDTH-1:0] q
);

    // Parallel load takes priority over shifting.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            q <= '0;
        end else if (load) begin
            q <= load_val;
        end else if (shift) begin
            q <= {q[WIDTH-2:0], ser_in};
        end
    end

endmodule

// File: rtl/scan_tester.sv
// Scan test controller: load a pattern, capture once, unload and score the response.
// Optional per-bit compare masking is enabled by defining SCAN_TESTER_MASK_EN.
module scan_tester
    import scan_pkg::*;
#(
    parameter int CHAIN_LEN = 4,
    parameter int CNT_W     = $clog2(CHAIN_LEN + 1)
) (
    input  logic          clk,
    input  logic          rst,
    scan_tester_if.slave  bus,
    input  logic          chain_so,
    output logic          scan_en,
    output logic          scan_in
);

    state_t               state;
    logic [CNT_W-1:0]     cnt;
    logic                 last_bit;
    logic                 accept;
    logic [CHAIN_LEN-1:0] pat_q;
    logic [CHAIN_LEN-1:0] resp_q;
    logic [CHAIN_LEN-1:0] exp_q;
    logic [CHAIN_LEN-1:0] diff;
`ifdef SCAN_TESTER_MASK_EN
    logic [CHAIN_LEN-1:0] mask_q;
`endif

    assign accept   = (state == IDLE) && bus.start;
    assign last_bit = (cnt == CNT_W'(CHAIN_LEN - 1));

    // The MSB goes straight into the scan_in flop at acceptance, so the
    // register holds the remaining bits pre-shifted one place.
    scan_shift_reg #(.WIDTH(CHAIN_LEN)) u_pattern (
        .clk      (clk),
        .rst      (rst),
        .load     (accept),
        .load_val ({bus.pattern[CHAIN_LEN-2:0], 1'b0}),
        .shift    (state == LOAD),
        .ser_in   (1'b0),
        .q        (pat_q)
    );

    scan_shift_reg #(.WIDTH(CHAIN_LEN)) u_response (
        .clk      (clk),
        .rst      (rst),
        .load     (accept),
        .load_val ('0),
        .shift    (state == UNLOAD),
        .ser_in   (chain_so),
        .q        (resp_q)
    );

    always_comb begin
`ifdef SCAN_TESTER_MASK_EN
        diff = (resp_q ^ exp_q) & ~mask_q;
`else
        diff = resp_q ^ exp_q;
`endif
    end

    // Sequencer FSM; every externally visible control bit is a flop here.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= IDLE;
            cnt          <= '0;
            scan_en      <= 1'b0;
            scan_in      <= 1'b0;
            exp_q        <= '0;
`ifdef SCAN_TESTER_MASK_EN
            mask_q       <= '0;
`endif
            bus.busy       <= 1'b0;
            bus.done       <= 1'b0;
            bus.pass       <= 1'b0;
            bus.fail_count <= '0;
            bus.response   <= '0;
        end else begin
            bus.done <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        state    <= LOAD;
                        cnt      <= '0;
                        exp_q    <= bus.expected;
`ifdef SCAN_TESTER_MASK_EN
                        mask_q   <= bus.mask;
`endif
                        scan_en  <= 1'b1;
                        scan_in  <= bus.pattern[CHAIN_LEN-1];
                        bus.busy <= 1'b1;
                    end
                end
                LOAD: begin
                    if (last_bit) begin
                        state   <= CAPTURE;
                        cnt     <= '0;
                        scan_en <= 1'b0;
                        scan_in <= 1'b0;
                    end else begin
                        cnt     <= cnt + 1'b1;
                        scan_in <= pat_q[CHAIN_LEN-1];
                    end
                end
                CAPTURE: begin
                    state   <= UNLOAD;
                    scan_en <= 1'b1;
                end
                UNLOAD: begin
                    if (last_bit) begin
                        state   <= CHECK;
                        cnt     <= '0;
                        scan_en <= 1'b0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                CHECK: begin
                    state          <= IDLE;
                    bus.busy       <= 1'b0;
                    bus.done       <= 1'b1;
                    bus.response   <= resp_q;
                    bus.fail_count <= CNT_W'(popcount(POP_W'(diff)));
                    bus.pass       <= (diff == '0);
                end
                default: begin
                    state    <= IDLE;
                    scan_en  <= 1'b0;
                    scan_in  <= 1'b0;
                    bus.busy <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_scan_tester.sv
// Scoreboard bench for scan_tester with a 4-flop chain that captures the
// inverse of its contents; exercises mask compare when SCAN_TESTER_MASK_EN is set.
module tb_scan_tester;

    localparam int N = 4;
    localparam logic [9:0] SCAN_EN_PROFILE = 10'b0111101111;

    typedef struct {
        logic [N-1:0] resp;
        logic         pass;
        logic [2:0]   fails;
        int           done_edge;
    } exp_t;

    logic clk;
    logic rst;
    logic chain_so;
    logic scan_en;
    logic scan_in;
    logic [N-1:0] chain;

    int   n_checks = 0;
    int   n_fails  = 0;
    int   edge_cnt = 0;
    exp_t sb_q[$];
    exp_t mon_e;

    scan_tester_if #(.CHAIN_LEN(N)) bus ();

    scan_tester #(.CHAIN_LEN(N)) dut (
        .clk      (clk),
        .rst      (rst),
        .bus      (bus),
        .chain_so (chain_so),
        .scan_en  (scan_en),
        .scan_in  (scan_in)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    // Chain model: shift-left in scan mode, capture the inverse otherwise.
    always @(posedge clk) begin
        if (scan_en) chain <= {chain[N-2:0], scan_in};
        else         chain <= ~chain;
    end
    assign chain_so = chain[N-1];

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] want);
        n_checks++;
        if (actual !== want) begin
            n_fails++;
            $display("[TB] FAIL %s: got %0h, want %0h at edge %0d", name, actual, want, edge_cnt);
        end
    endtask

    task automatic checkIdleOutputs(input string tag);
        checkOutput({tag, "_scan_en"},    scan_en, 0);
        checkOutput({tag, "_scan_in"},    scan_in, 0);
        checkOutput({tag, "_busy"},       bus.busy, 0);
        checkOutput({tag, "_done"},       bus.done, 0);
        checkOutput({tag, "_pass"},       bus.pass, 0);
        checkOutput({tag, "_fail_count"}, bus.fail_count, 0);
        checkOutput({tag, "_response"},   bus.response, 0);
    endtask

    // Called at a falling edge: the next rising edge is edge 0 of the test.
    task automatic applyStimulus(input logic [N-1:0] pat, input logic [N-1:0] exp_v,
                                 input logic [N-1:0] resp, input logic ps, input logic [2:0] fc);
        exp_t e;
        bus.start    = 1'b1;
        bus.pattern  = pat;
        bus.expected = exp_v;
        e.resp      = resp;
        e.pass      = ps;
        e.fails     = fc;
        e.done_edge = edge_cnt + 2 * N + 3;
        sb_q.push_back(e);
    endtask

    task automatic runTest(input logic [N-1:0] pat, input logic [N-1:0] exp_v,
                           input logic [N-1:0] resp, input logic ps, input logic [2:0] fc,
                           input bit spurious);
        logic [9:0] profile;
        profile = SCAN_EN_PROFILE;
        applyStimulus(pat, exp_v, resp, ps, fc);
        for (int k = 0; k <= 2 * N + 2; k++) begin
            @(negedge clk);
            bus.start = 1'b0;
            if (spurious && (k == 2 || k == 9)) begin
                bus.start    = 1'b1;
                bus.pattern  = 4'b0000;
                bus.expected = 4'b1111;
            end
            if (k <= 2 * N + 1) begin
                checkOutput("scan_en", scan_en, profile[k]);
                checkOutput("busy", bus.busy, 1);
                if (k < N) checkOutput("scan_in", scan_in, pat[N-1-k]);
            end else begin
                checkOutput("busy_end", bus.busy, 0);
            end
        end
    endtask

    // Monitor: every done pulse must match the oldest outstanding test.
    always @(negedge clk) begin
        if (bus.done === 1'b1) begin
            if (sb_q.size() == 0) begin
                n_checks++;
                n_fails++;
                $display("[TB] FAIL unexpected_done: got done=1, want no pending test at edge %0d", edge_cnt);
            end else begin
                mon_e = sb_q.pop_front();
                checkOutput("response",   bus.response,   mon_e.resp);
                checkOutput("pass",       bus.pass,       mon_e.pass);
                checkOutput("fail_count", bus.fail_count, mon_e.fails);
                checkOutput("done_edge",  edge_cnt,       mon_e.done_edge);
            end
        end
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: got no finish, want finish before 100us");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst          = 1'b0;
        bus.start    = 1'b0;
        bus.pattern  = '0;
        bus.expected = '0;
`ifdef SCAN_TESTER_MASK_EN
        bus.mask     = '0;
`endif
        repeat (3) @(negedge clk);
        checkIdleOutputs("in_reset");
        rst = 1'b1;
        repeat (3) @(negedge clk);
        checkIdleOutputs("idle");

        $display("[TB] pass case, then back-to-back fail case");
        runTest(4'b1011, 4'b0100, 4'b0100, 1'b1, 3'd0, 1'b0);
        runTest(4'b1011, 4'b0111, 4'b0100, 1'b0, 3'd2, 1'b0);
        repeat (3) @(negedge clk);
        checkOutput("hold_response",   bus.response,   4'b0100);
        checkOutput("hold_fail_count", bus.fail_count, 2);
        checkOutput("hold_pass",       bus.pass,       0);

        $display("[TB] start pulses while busy");
        runTest(4'b1011, 4'b0100, 4'b0100, 1'b1, 3'd0, 1'b1);
        repeat (2) @(negedge clk);

        $display("[TB] reset during load");
        applyStimulus(4'b1011, 4'b0111, 4'b0100, 1'b0, 3'd2);
        @(posedge clk);
        #1 bus.start = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #2 rst = 1'b0;
        #1;
        checkOutput("abort_scan_en", scan_en, 0);
        checkOutput("abort_busy",    bus.busy, 0);
        sb_q.delete();
        repeat (12) @(negedge clk);
        checkIdleOutputs("after_abort");
        rst = 1'b1;
        repeat (2) @(negedge clk);
        runTest(4'b0000, 4'b1111, 4'b1111, 1'b1, 3'd0, 1'b0);

`ifdef SCAN_TESTER_MASK_EN
        $display("[TB] masked compare");
        @(negedge clk);
        bus.mask = 4'b0011;
        runTest(4'b1011, 4'b0111, 4'b0100, 1'b1, 3'd0, 1'b0);
        bus.mask = 4'b0000;
`endif

        repeat (4) @(negedge clk);
        checkOutput("scoreboard_empty", sb_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule

// File: doc/scan_tester.md
# scan_tester

On-chip scan test controller: the driving end of a single scan chain built from shift-left scan flops (scan data enters at the LSB, scan output is the MSB). Per test it:
- shifts a stored pattern into the chain;
- releases scan mode for one functional capture cycle;
- shifts the captured response out and compares it against an expected vector.

It sits between a test sequencer (start/done handshake) and any scan-enabled datapath block with scan_en/scan_in/scan_out pins.

## Interface
- CHAIN_LEN, 4, number of flops in the attached chain; legal range ≥2.
- CNT_W, $clog2(CHAIN_LEN+1), width of bit counter and fail_count.
- clk  input  1  clock.
- rst  input  1  asynchronous reset, active-low.
- start  input  1  request one test; accepted only when busy=0.
- pattern  input  CHAIN_LEN  vector to load; bit CHAIN_LEN-1 lands in the chain MSB.
- expected  input  CHAIN_LEN  golden response.
- chain_so  input  1  scan output of the attached chain.
- scan_en  output  1  scan mode enable to the chain.
- scan_in  output  1  serial data to the chain.
- busy  output  1  test in progress.
- done  output  1  one-cycle pulse; result valid.
- pass  output  1  1 when response matches expected (masked per Configuration).
- fail_count  output  CNT_W  number of mismatching bits.
- response  output  CHAIN_LEN  unloaded chain contents, MSB = chain MSB.

## Operation
- FSM states:
  - IDLE → LOAD on start (latch pattern, expected; counter=0).
  - LOAD: CHAIN_LEN cycles, then → CAPTURE.
  - CAPTURE: 1 cycle, then → UNLOAD.
  - UNLOAD: CHAIN_LEN cycles, then → CHECK.
  - CHECK: 1 cycle, then → IDLE.
- LOAD: scan_en=1; scan_in = latched pattern bits, MSB first, one bit per cycle.
- CAPTURE: scan_en=0, scan_in=0; the chain loads its functional value. The system holds the chain's functional inputs stable during this cycle.
- UNLOAD: scan_en=1, scan_in=0; chain_so is sampled every edge and shifted into response from the LSB. After CHAIN_LEN samples, response equals the captured chain contents.
- CHECK: registers fail_count = popcount(response ^ expected), pass = (fail_count==0), and pulses done.
- response, pass and fail_count hold until the next CHECK.
- start while busy=1 is ignored, and pattern/expected changes after acceptance have no effect.
- start in the same cycle as done (state IDLE) is accepted: back-to-back tests.
- Reset (any time, including mid-shift): state=IDLE, scan_en=0, scan_in=0, busy=0, done=0, pass=0, fail_count=0, response=0. The chain contents are then undefined to the bench.

## Timing
- scan_en, scan_in, busy and done are driven directly from flops: no combinational path from inputs to outputs.
- start is sampled at edge 0.
- busy rises after edge 0 and falls after edge 2N+2 (N=CHAIN_LEN).
- Shift-in edges: 1..N. Capture edge: N+1. Unload sample edges: N+2..2N+1. done is high during the cycle after edge 2N+2.
- For N=4, done is high after edge 10; total occupancy is 2N+2 cycles.
- chain_so is sampled on the same edge at which the chain shifts, so the first sample is the captured MSB.

## Configuration
- SCAN_TESTER_MASK_EN defined: adds input port mask [CHAIN_LEN-1:0], latched at start. Bits with mask=1 are excluded from the compare: fail_count = popcount((response ^ expected) & ~mask).
- SCAN_TESTER_MASK_EN undefined: no mask port; all bits are compared.

## Structure
- Shared package scan_pkg holds:
  - the state enum (IDLE, LOAD, CAPTURE, UNLOAD, CHECK);
  - localparams for the state encoding;
  - a popcount function used by CHECK.
- One sub-module: scan_shift_reg, a parameterised shift-left register with serial input, parallel load and parallel output. It is instantiated twice: once for the pattern (serial out) and once for the response (serial in).

## Test plan
Bench chain model: 4 flops, shift-left when scan_en=1; when scan_en=0 it captures the bitwise NOT of its contents. CHAIN_LEN=4.
- Reset: hold rst=0 → all outputs 0, scan_en=0. Release, no start → outputs stay 0.
- Pass case: pattern=4'b1011, expected=4'b0100 → done after edge 10, response=4'b0100, pass=1, fail_count=0, scan_en high on edges 1–4 and 6–9.
- Fail case: pattern=4'b1011, expected=4'b0111 → response=4'b0100, pass=0, fail_count=2.
- Handshake: start pulses while busy → ignored, done still after edge 10. start during the done cycle → second test begins, its done 10 cycles later.
- Reset mid-LOAD at edge 2 → scan_en and busy drop immediately, done never pulses. A subsequent test with pattern=4'b0000, expected=4'b1111 → pass=1.
- With SCAN_TESTER_MASK_EN: pattern=4'b1011, expected=4'b0111, mask=4'b0011 → pass=1, fail_count=0.
